cache_refill_writer: RTL and testbench



---
 rtl/cache_refill_writer.sv | 177 +++++++++++++++++
 tb/tb_cache_refill_writer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_writer.sv
// -----------------------------------------------------------------------------
// cache_refill_writer
//
// Line-fill stage feeding the second write port of the cache data array.
// A refill request names a line index and the critical word offset; the
// block then consumes a burst of memory beats and writes each beat as a
// full-word write, in wrap-around order starting at the critical word.
// A per-word bitmap (word_ready_o) tells the load path which words of the
// line have already been committed, so a waiting load can restart early.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o   refill request handshake (ready only in IDLE)
//   req_index_i               line index
//   req_offset_i              critical (first) word offset within the line
//   beat_valid_i/beat_ready_o memory beat handshake (ready only in FILL)
//   beat_data_i, beat_last_i  beat payload and end-of-burst marker
//   bram_write_en_o           byte enables for the array port (all 1s or 0s)
//   bram_addr_o, bram_data_o  write address {index, ptr} and write data
//   word_ready_o              bit i set once word i of the line is committed
//   busy_o                    a refill is in progress
//   done_o, error_o           one-cycle end-of-refill pulse and its status
// -----------------------------------------------------------------------------
module cache_refill_writer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int OFFSET_BITS = 3
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [ADDR_WIDTH-OFFSET_BITS-1:0] req_index_i,
  input  logic [OFFSET_BITS-1:0]            req_offset_i,
  input  logic                              beat_valid_i,
  output logic                              beat_ready_o,
  input  logic [DATA_WIDTH-1:0]             beat_data_i,
  input  logic                              beat_last_i,
  output logic [DATA_WIDTH/8-1:0]           bram_write_en_o,
  output logic [ADDR_WIDTH-1:0]             bram_addr_o,
  output logic [DATA_WIDTH-1:0]             bram_data_o,
  output logic [(2**OFFSET_BITS)-1:0]       word_ready_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              error_o
);

  localparam int WORDS      = 2 ** OFFSET_BITS;
  localparam int INDEX_BITS = ADDR_WIDTH - OFFSET_BITS;
  localparam int BE_BITS    = DATA_WIDTH / 8;

  localparam logic [OFFSET_BITS:0] LAST_COUNT = (OFFSET_BITS + 1)'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } StateT;

  StateT                   state_q;
  logic [INDEX_BITS-1:0]   index_q;
  logic [OFFSET_BITS-1:0]  ptr_q;
  logic [OFFSET_BITS:0]    count_q;
  logic                    errFlag_q;
  logic [WORDS-1:0]        wordReady_q;
  logic [BE_BITS-1:0]      writeEn_q;
  logic [ADDR_WIDTH-1:0]   writeAddr_q;
  logic [DATA_WIDTH-1:0]   writeData_q;
  logic                    reqReady_q;
  logic                    beatReady_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;

  // Refill controller. All handshake and status outputs are registered and
  // updated on the same edge as the state, so each one is a clean function
  // of the state it is entering. The write port is a one-deep pipeline:
  // a beat accepted in one cycle is presented on the array port during the
  // next cycle only. The word_ready bit for a write is raised on the edge
  // that ends the write cycle, i.e. when the array has actually committed
  // it. A write already on the port when reset is asserted still reaches
  // the array because the port is driven straight from these registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      index_q     <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      errFlag_q   <= 1'b0;
      wordReady_q <= '0;
      writeEn_q   <= '0;
      writeAddr_q <= '0;
      writeData_q <= '0;
      reqReady_q  <= 1'b1;
      beatReady_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      writeEn_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;

      if (writeEn_q != '0) begin
        wordReady_q[writeAddr_q[OFFSET_BITS-1:0]] <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            index_q     <= req_index_i;
            ptr_q       <= req_offset_i;
            count_q     <= '0;
            errFlag_q   <= 1'b0;
            wordReady_q <= '0;
            state_q     <= FILL;
            reqReady_q  <= 1'b0;
            beatReady_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        FILL: begin
          if (beat_valid_i) begin
            writeEn_q   <= '1;
            writeAddr_q <= {index_q, ptr_q};
            writeData_q <= beat_data_i;
            ptr_q       <= ptr_q + 1'b1;
            count_q     <= count_q + 1'b1;
            if (beat_last_i || (count_q == LAST_COUNT)) begin
              state_q     <= DRAIN;
              beatReady_q <= 1'b0;
            end
            if (beat_last_i && (count_q < LAST_COUNT)) begin
              errFlag_q <= 1'b1;
            end
            if (!beat_last_i && (count_q == LAST_COUNT)) begin
              errFlag_q <= 1'b1;
            end
          end
        end

        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          error_q <= errFlag_q;
        end

        DONE: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b1;
          busy_q     <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          reqReady_q  <= 1'b1;
          beatReady_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are taken directly from the registers above.
  assign req_ready_o     = reqReady_q;
  assign beat_ready_o    = beatReady_q;
  assign bram_write_en_o = writeEn_q;
  assign bram_addr_o     = writeAddr_q;
  assign bram_data_o     = writeData_q;
  assign word_ready_o    = wordReady_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_cache_refill_writer.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_writer
//
// Self-checking bench for cache_refill_writer. The driver issues refills and
// beats (directed cases plus randomized bursts) and, from the burst rules,
// pushes the expected writes, word_ready updates and done events into
// queues. A monitor on the falling edge pops and compares whenever the DUT
// presents a write or a done pulse, and tracks the expected word_ready map.
// -----------------------------------------------------------------------------
module tb_cache_refill_writer;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int OB    = 3;
  localparam int WORDS = 2 ** OB;
  localparam int IW    = AW - OB;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [IW-1:0]     req_index_i;
  logic [OB-1:0]     req_offset_i;
  logic              beat_valid_i;
  logic              beat_ready_o;
  logic [DW-1:0]     beat_data_i;
  logic              beat_last_i;
  logic [DW/8-1:0]   bram_write_en_o;
  logic [AW-1:0]     bram_addr_o;
  logic [DW-1:0]     bram_data_o;
  logic [WORDS-1:0]  word_ready_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;

  cache_refill_writer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .OFFSET_BITS(OB)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_index_i    (req_index_i),
    .req_offset_i   (req_offset_i),
    .beat_valid_i   (beat_valid_i),
    .beat_ready_o   (beat_ready_o),
    .beat_data_i    (beat_data_i),
    .beat_last_i    (beat_last_i),
    .bram_write_en_o(bram_write_en_o),
    .bram_addr_o    (bram_addr_o),
    .bram_data_o    (bram_data_o),
    .word_ready_o   (word_ready_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Cycle counter; a cycle's number is the value seen at its falling edge.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } WriteT;

  typedef struct {
    int               cyc;
    logic             err;
    logic [WORDS-1:0] ready;
  } DoneT;

  typedef struct {
    int cyc;
    bit clr;
    int idx;
  } EventT;

  WriteT expWrites[$];
  DoneT  expDones[$];
  EventT expEvents[$];

  int               checks = 0;
  int               errors = 0;
  bit               monOn  = 1'b0;
  logic [WORDS-1:0] modelReady = '0;

  WriteT monW;
  DoneT  monD;
  EventT monE;

  // Shared comparison helper: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: applies due word_ready model events, then compares word_ready
  // every cycle and pops the scoreboard whenever a write or done appears.
  always @(negedge clk_i) begin
    if (monOn) begin
      while (expEvents.size() > 0 && expEvents[0].cyc <= cyc) begin
        monE = expEvents.pop_front();
        if (monE.clr) modelReady = '0;
        else          modelReady[monE.idx] = 1'b1;
      end
      checkOutput("word_ready", 64'(word_ready_o), 64'(modelReady));

      if (bram_write_en_o != '0) begin
        if (expWrites.size() == 0) begin
          checkOutput("unexpected_write", 64'(bram_addr_o), 64'hFFFF_FFFF);
        end else begin
          monW = expWrites.pop_front();
          checkOutput("write_cycle", 64'(cyc), 64'(monW.cyc));
          checkOutput("write_be", 64'(bram_write_en_o), 64'hF);
          checkOutput("write_addr", 64'(bram_addr_o), 64'(monW.addr));
          checkOutput("write_data", 64'(bram_data_o), 64'(monW.data));
        end
      end

      if (done_o) begin
        if (expDones.size() == 0) begin
          checkOutput("unexpected_done", 64'(done_o), 64'h0);
        end else begin
          monD = expDones.pop_front();
          checkOutput("done_cycle", 64'(cyc), 64'(monD.cyc));
          checkOutput("done_error", 64'(error_o), 64'(monD.err));
          checkOutput("done_word_ready", 64'(word_ready_o), 64'(monD.ready));
        end
      end
    end
  end

  // One refill. lastPos: beat number (1..8) carrying beat_last, 0 for none.
  // resetAfter: assert reset right after that many beats are accepted.
  task automatic applyStimulus(input logic [IW-1:0] idx, input logic [OB-1:0] off,
                               input int lastPos, input int gapPct,
                               input int resetAfter, input logic [DW-1:0] base,
                               input bit randData, input bit extraBeats);
    int               nAcc;
    bit               acc;
    bit               errExp;
    logic [OB-1:0]    p;
    logic [DW-1:0]    d;
    logic [WORDS-1:0] bm;
    int               tFinal;
    int               gaps;

    nAcc   = (lastPos >= 1 && lastPos <= WORDS) ? lastPos : WORDS;
    errExp = (lastPos != WORDS);
    bm     = '0;
    tFinal = 0;

    req_index_i  = idx;
    req_offset_i = off;
    req_valid_i  = 1'b1;
    acc = 1'b0;
    for (int w = 0; w < 50 && !acc; w++) begin
      @(negedge clk_i);
      acc = req_ready_o;
      if (acc) expEvents.push_back('{cyc + 1, 1'b1, 0});
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    if (!acc) begin
      checkOutput("req_timeout", 64'(acc), 64'h1);
      return;
    end

    p = off;
    for (int k = 1; k <= nAcc; k++) begin
      d = randData ? DW'($urandom) : base + DW'(k - 1);
      gaps = 0;
      while (gaps < 5 && int'($urandom_range(99)) < gapPct) begin
        beat_valid_i = 1'b0;
        @(posedge clk_i); #1;
        gaps++;
      end
      beat_valid_i = 1'b1;
      beat_data_i  = d;
      beat_last_i  = (k == lastPos);
      acc = 1'b0;
      for (int w = 0; w < 50 && !acc; w++) begin
        @(negedge clk_i);
        acc = beat_ready_o;
        if (acc) begin
          expWrites.push_back('{cyc + 1, {idx, p}, d});
          expEvents.push_back('{cyc + 2, 1'b0, int'(p)});
          bm[p]  = 1'b1;
          tFinal = cyc;
        end
        @(posedge clk_i); #1;
      end
      beat_valid_i = 1'b0;
      beat_last_i  = 1'b0;
      if (!acc) begin
        checkOutput("beat_timeout", 64'(acc), 64'h1);
        return;
      end
      p = p + 1'b1;

      if (k == resetAfter) begin
        reset_i = 1'b1;
        expEvents.push_back('{cyc + 1, 1'b1, 0});
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rst_write_en", 64'(bram_write_en_o), 64'h0);
        checkOutput("rst_req_ready", 64'(req_ready_o), 64'h1);
        checkOutput("rst_busy", 64'(busy_o), 64'h0);
        checkOutput("rst_word_ready", 64'(word_ready_o), 64'h0);
        @(posedge clk_i); #1;
        return;
      end
    end

    expDones.push_back('{tFinal + 2, errExp, bm});

    if (extraBeats) begin
      beat_valid_i = 1'b1;
      for (int j = 0; j < 3; j++) begin
        beat_data_i = DW'($urandom);
        @(posedge clk_i); #1;
      end
      beat_valid_i = 1'b0;
    end else begin
      repeat (2) begin
        @(posedge clk_i); #1;
      end
    end
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset checks, directed refills, randomized refills.
  initial begin
    int r;
    int lp;
    reset_i      = 1'b1;
    req_valid_i  = 1'b0;
    req_index_i  = '0;
    req_offset_i = '0;
    beat_valid_i = 1'b0;
    beat_data_i  = '0;
    beat_last_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_req_ready", 64'(req_ready_o), 64'h1);
    checkOutput("reset_beat_ready", 64'(beat_ready_o), 64'h0);
    checkOutput("reset_write_en", 64'(bram_write_en_o), 64'h0);
    checkOutput("reset_word_ready", 64'(word_ready_o), 64'h0);
    checkOutput("reset_busy", 64'(busy_o), 64'h0);
    checkOutput("reset_done", 64'(done_o), 64'h0);
    checkOutput("reset_error", 64'(error_o), 64'h0);
    modelReady = '0;
    monOn = 1'b1;
    @(posedge clk_i); #1;

    applyStimulus(7'd5, 3'd0, 8, 0, 0, 32'h100, 1'b0, 1'b0);
    applyStimulus(7'd3, 3'd6, 8, 0, 0, 32'hA0, 1'b0, 1'b0);
    applyStimulus(7'd7, 3'd2, 8, 50, 0, 32'h0, 1'b1, 1'b0);
    applyStimulus(7'd9, 3'd1, 3, 0, 0, 32'h300, 1'b0, 1'b1);
    applyStimulus(7'd11, 3'd4, 0, 0, 0, 32'h400, 1'b0, 1'b1);
    applyStimulus(7'd2, 3'd5, 8, 0, 4, 32'h500, 1'b0, 1'b0);
    applyStimulus(7'd12, 3'd3, 8, 0, 0, 32'h600, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      r  = int'($urandom_range(99));
      lp = (r < 70) ? 8 : (r < 85) ? int'($urandom_range(7, 1)) : 0;
      applyStimulus(IW'($urandom), OB'($urandom), lp,
                    int'($urandom_range(50)), 0, '0, 1'b1, 1'(r % 2));
    end

    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("pending_writes", 64'(expWrites.size()), 64'h0);
    checkOutput("pending_dones", 64'(expDones.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
